// File: rtl/int_rf_read_arb_if.sv
// Issue-port / regfile-read bundle between the integer reservation stations and the read arbiter.
// master = RS side (issues requests), slave = arbiter (drives regfile reads and feedback).
interface int_rf_read_arb_if #(
    parameter int REQ_NUM    = 4,
    parameter int SRC_NUM    = 2,
    parameter int RDPORT_NUM = 6,
    parameter int IDX_W      = 3,
    parameter int PRF_W      = 7
);
    logic [REQ_NUM-1:0]                           req_vld;
    logic [REQ_NUM-1:0][IDX_W-1:0]                req_entry_idx;
    logic [REQ_NUM-1:0][SRC_NUM-1:0]              req_src_ren;
    logic [REQ_NUM-1:0][SRC_NUM-1:0][PRF_W-1:0]   req_src_idx;
    logic [RDPORT_NUM-1:0]                        port_busy;
    logic                                         flush;

    logic [RDPORT_NUM-1:0]                        rf_ren;
    logic [RDPORT_NUM-1:0][PRF_W-1:0]             rf_raddr;
    logic [REQ_NUM-1:0]                           deq_vld;
    logic [REQ_NUM-1:0]                           replay_vld;
    logic [REQ_NUM-1:0][IDX_W-1:0]                feedback_idx;

    modport master (
        output req_vld, req_entry_idx, req_src_ren, req_src_idx, port_busy, flush,
        input  rf_ren, rf_raddr, deq_vld, replay_vld, feedback_idx
    );

    modport slave (
        input  req_vld, req_entry_idx, req_src_ren, req_src_idx, port_busy, flush,
        output rf_ren, rf_raddr, deq_vld, replay_vld, feedback_idx
    );
endinterface

// File: rtl/int_rf_read_arb.sv
// Shares the integer regfile read ports among the RS issue ports: combinational grant and port
// packing in cycle T, registered deq/replay feedback aligned with the read data in T+1.
module int_rf_read_arb #(
    parameter int REQ_NUM      = 4,
    parameter int SRC_NUM      = 2,
    parameter int RDPORT_NUM   = 6,
    parameter int IDX_W        = 3,
    parameter int PRF_W        = 7,
    parameter int STARVE_LIMIT = 3
) (
    input  logic               clk,
    input  logic               rst,
    int_rf_read_arb_if.slave   rf
);
    localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [PTR_W-1:0]                 rr_ptr;
    logic [CNT_W-1:0]                 starve_cnt [REQ_NUM];
    logic [REQ_NUM-1:0]               starving;
    logic [REQ_NUM-1:0]               grant;
    logic [RDPORT_NUM-1:0]            ren_c;
    logic [RDPORT_NUM-1:0][PRF_W-1:0] raddr_c;

    always_comb begin
        for (int r = 0; r < REQ_NUM; r++) begin
            starving[r] = (starve_cnt[r] == CNT_W'(STARVE_LIMIT));
        end
    end

    // Pass 0 visits starving requesters, pass 1 the rest, each in rotation order from rr_ptr.
    // Granted sources then take the lowest free non-busy port, so packing follows scan order.
    always_comb begin : arbitrate
        int                    remaining;
        int                    need;
        int                    slot;
        logic                  placed;
        logic [RDPORT_NUM-1:0] used;

        // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
        grant     = '0;
        ren_c     = '0;
        raddr_c   = '0;
        used      = '0;
        placed    = 1'b0;
        need      = 0;
        slot      = 0;
        remaining = RDPORT_NUM;
        for (int p = 0; p < RDPORT_NUM; p++) begin
            remaining = remaining - int'(rf.port_busy[p]);
        end

        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < REQ_NUM; i++) begin
                slot = int'(rr_ptr) + i;
                if (slot >= REQ_NUM) slot = slot - REQ_NUM;
                for (int r = 0; r < REQ_NUM; r++) begin
                    if (r == slot && rf.req_vld[r] && !rf.flush &&
                        (starving[r] == (pass == 0))) begin
                        need = 0;
                        for (int s = 0; s < SRC_NUM; s++) begin
                            need = need + int'(rf.req_src_ren[r][s]);
                        end
                        if (need <= remaining) begin
                            grant[r]  = 1'b1;
                            remaining = remaining - need;
                            for (int s = 0; s < SRC_NUM; s++) begin
                                placed = 1'b0;
                                for (int p = 0; p < RDPORT_NUM; p++) begin
                                    if (rf.req_src_ren[r][s] && !placed &&
                                        !rf.port_busy[p] && !used[p]) begin
                                        used[p]    = 1'b1;
                                        ren_c[p]   = 1'b1;
                                        raddr_c[p] = rf.req_src_idx[r][s];
                                        placed     = 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    assign rf.rf_ren   = rst ? '0 : ren_c;
    assign rf.rf_raddr = rst ? '0 : raddr_c;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr          <= '0;
            rf.deq_vld      <= '0;
            rf.replay_vld   <= '0;
            rf.feedback_idx <= '0;
            // NOTE: the counter array is a handful of flops, not a RAM, so it is reset element-wise.
            for (int r = 0; r < REQ_NUM; r++) begin
                starve_cnt[r] <= '0;
            end
        end else begin
            rf.deq_vld    <= grant;
            rf.replay_vld <= rf.flush ? '0 : (rf.req_vld & ~grant);
            for (int r = 0; r < REQ_NUM; r++) begin
                if (rf.req_vld[r]) begin
                    rf.feedback_idx[r] <= rf.req_entry_idx[r];
                end
                if (rf.flush) begin
                    starve_cnt[r] <= '0;
                end else if (rf.req_vld[r]) begin
                    if (grant[r]) begin
                        starve_cnt[r] <= '0;
                    end else if (!starving[r]) begin
                        starve_cnt[r] <= starve_cnt[r] + 1'b1;
                    end
                end
            end
            if (!rf.flush && (|rf.req_vld)) begin
                rr_ptr <= (rr_ptr == PTR_W'(REQ_NUM - 1)) ? '0 : rr_ptr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_int_rf_read_arb.sv
// Directed bench for int_rf_read_arb: comb port outputs checked in T, expected feedback queued
// in a scoreboard and popped one cycle later.
module tb_int_rf_read_arb;
    localparam int REQ_NUM    = 4;
    localparam int SRC_NUM    = 2;
    localparam int RDPORT_NUM = 6;
    localparam int IDX_W      = 3;
    localparam int PRF_W      = 7;

    typedef logic [RDPORT_NUM-1:0][PRF_W-1:0] addr_t;
    typedef logic [REQ_NUM-1:0][IDX_W-1:0]    idx_t;
    typedef struct {
        string                tag;
        logic [REQ_NUM-1:0]   deq;
        logic [REQ_NUM-1:0]   rep;
        idx_t                 idx;
    } fb_t;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    fb_t  sb[$];

    int_rf_read_arb_if #(
        .REQ_NUM(REQ_NUM), .SRC_NUM(SRC_NUM), .RDPORT_NUM(RDPORT_NUM),
        .IDX_W(IDX_W), .PRF_W(PRF_W)
    ) bus ();

    int_rf_read_arb #(
        .REQ_NUM(REQ_NUM), .SRC_NUM(SRC_NUM), .RDPORT_NUM(RDPORT_NUM),
        .IDX_W(IDX_W), .PRF_W(PRF_W), .STARVE_LIMIT(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rf  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic addr_t mk_addr(input int a0, a1, a2, a3, a4, a5);
        addr_t v;
        v[0] = 7'(a0); v[1] = 7'(a1); v[2] = 7'(a2);
        v[3] = 7'(a3); v[4] = 7'(a4); v[5] = 7'(a5);
        return v;
    endfunction

    function automatic idx_t mk_idx(input int i0, i1, i2, i3);
        idx_t v;
        v[0] = 3'(i0); v[1] = 3'(i1); v[2] = 3'(i2); v[3] = 3'(i3);
        return v;
    endfunction

    // Source s of requester r reads physical register 16*r + s + 1.
    task automatic set_req(input logic [1:0] r, input logic vld, input logic [2:0] idx,
                           input logic [1:0] ren);
        bus.req_vld[r]        = vld;
        bus.req_entry_idx[r]  = idx;
        bus.req_src_ren[r]    = ren;
        bus.req_src_idx[r][0] = 7'({r, 4'h1});
        bus.req_src_idx[r][1] = 7'({r, 4'h2});
    endtask

    task automatic set_all(input logic vld, input logic [1:0] ren);
        for (int i = 0; i < REQ_NUM; i++) set_req(2'(i), vld, 3'(i + 1), ren);
    endtask

    // Inputs are already applied; check cycle-T outputs, queue T+1 feedback, then compare it.
    task automatic step(input string tag, input logic [5:0] e_ren, input addr_t e_addr,
                        input logic [3:0] e_deq, input logic [3:0] e_rep, input idx_t e_idx);
        fb_t item;
        #1;
        check({tag, "_ren"},   64'(bus.rf_ren),   64'(e_ren));
        check({tag, "_raddr"}, 64'(bus.rf_raddr), 64'(e_addr));
        item.tag = tag; item.deq = e_deq; item.rep = e_rep; item.idx = e_idx;
        sb.push_back(item);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            item = sb.pop_front();
            check({item.tag, "_deq"},    64'(bus.deq_vld),      64'(item.deq));
            check({item.tag, "_replay"}, 64'(bus.replay_vld),   64'(item.rep));
            check({item.tag, "_fbidx"},  64'(bus.feedback_idx), 64'(item.idx));
        end
    endtask

    initial begin
        rst               = 1'b1;
        bus.req_vld       = '0;
        bus.req_entry_idx = '0;
        bus.req_src_ren   = '0;
        bus.req_src_idx   = '0;
        bus.port_busy     = '0;
        bus.flush         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("por_ren",   64'(bus.rf_ren),       64'd0);
        check("por_deq",   64'(bus.deq_vld),      64'd0);
        check("por_fbidx", 64'(bus.feedback_idx), 64'd0);
        rst = 1'b0;

        // Warm-up leaves rr_ptr=1 and req3 with one replay before the mid-run reset.
        set_all(1'b1, 2'b11);
        step("warm", 6'b111111, mk_addr(1, 2, 17, 18, 33, 34), 4'b0111, 4'b1000, mk_idx(1, 2, 3, 4));

        // Reset with requests pending: everything drops at once, not at the next edge.
        rst = 1'b1;
        #1;
        check("rst_ren",    64'(bus.rf_ren),       64'd0);
        check("rst_raddr",  64'(bus.rf_raddr),     64'd0);
        check("rst_deq",    64'(bus.deq_vld),      64'd0);
        check("rst_replay", 64'(bus.replay_vld),   64'd0);
        check("rst_fbidx",  64'(bus.feedback_idx), 64'd0);
        @(posedge clk);
        #1;
        check("rst_hold_ren", 64'(bus.rf_ren), 64'd0);
        rst = 1'b0;

        // Same stimulus as warm-up: identical result proves rr_ptr and counters went back to 0.
        step("t2", 6'b111111, mk_addr(1, 2, 17, 18, 33, 34), 4'b0111, 4'b1000, mk_idx(1, 2, 3, 4));

        // Starvation build-up: req3 is refused at rr=1,2,3 while port supply shrinks.
        bus.port_busy = 6'b000011;
        step("t3_c1", 6'b111100, mk_addr(0, 0, 17, 18, 33, 34), 4'b0110, 4'b1001, mk_idx(1, 2, 3, 4));
        bus.port_busy = 6'b001111;
        step("t3_c2", 6'b110000, mk_addr(0, 0, 0, 0, 33, 34), 4'b0100, 4'b1011, mk_idx(1, 2, 3, 4));
        bus.port_busy = 6'b111111;
        step("t3_c3", 6'b000000, mk_addr(0, 0, 0, 0, 0, 0), 4'b0000, 4'b1111, mk_idx(1, 2, 3, 4));
        // rr=0, req0 and req3 starving: req3 jumps ahead of req1/req2.
        bus.port_busy = 6'b000011;
        step("t3_c4", 6'b111100, mk_addr(0, 0, 1, 2, 49, 50), 4'b1001, 4'b0110, mk_idx(1, 2, 3, 4));

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Busy low ports, mixed needs; req3 idle so its feedback index keeps the reset value.
        bus.port_busy = 6'b000011;
        set_req(2'd0, 1'b1, 3'd5, 2'b11);
        set_req(2'd1, 1'b1, 3'd6, 2'b01);
        set_req(2'd2, 1'b1, 3'd7, 2'b11);
        set_req(2'd3, 1'b0, 3'd3, 2'b11);
        step("t4", 6'b011100, mk_addr(0, 0, 1, 2, 17, 0), 4'b0011, 4'b0100, mk_idx(5, 6, 7, 0));

        // No free port: only the zero-need request goes through.
        bus.port_busy = 6'b111111;
        set_all(1'b1, 2'b11);
        set_req(2'd1, 1'b1, 3'd2, 2'b00);
        step("t5", 6'b000000, mk_addr(0, 0, 0, 0, 0, 0), 4'b0010, 4'b1101, mk_idx(1, 2, 3, 4));

        // Idle cycle: no feedback, indexes hold despite new values on the bus.
        bus.port_busy = 6'b000000;
        for (int i = 0; i < REQ_NUM; i++) set_req(2'(i), 1'b0, 3'd7, 2'b11);
        step("idle", 6'b000000, mk_addr(0, 0, 0, 0, 0, 0), 4'b0000, 4'b0000, mk_idx(1, 2, 3, 4));

        // Flush with four valid requests.
        set_all(1'b1, 2'b11);
        bus.flush = 1'b1;
        step("t6_flush", 6'b000000, mk_addr(0, 0, 0, 0, 0, 0), 4'b0000, 4'b0000, mk_idx(1, 2, 3, 4));
        bus.flush = 1'b0;

        // After flush rr_ptr is still 2 and counters restart: one all-refused cycle, then rr=3
        // with two ports picks req3 (a stale counter would have made req2 starving instead).
        bus.port_busy = 6'b111111;
        step("t6_a", 6'b000000, mk_addr(0, 0, 0, 0, 0, 0), 4'b0000, 4'b1111, mk_idx(1, 2, 3, 4));
        bus.port_busy = 6'b001111;
        step("t6_b", 6'b110000, mk_addr(0, 0, 0, 0, 49, 50), 4'b1000, 4'b0111, mk_idx(1, 2, 3, 4));

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
